rst_wdog_ctrl: RTL and testbench

//  Synthesisable reset sequencer and run watchdog for multi-domain benches and SoC tops.

---
 rtl/rst_wdog_pkg.sv | 20 ++
 rtl/rst_wdog_ctrl.sv | 151 +++++++++++++++
 tb/tb_rst_wdog_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_wdog_pkg.sv
// Shared state encoding and default parameter values for the reset sequencer / run watchdog.
package rst_wdog_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    STAGGER = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    PASS    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  localparam int DEF_NUM_DOMAINS    = 4;
  localparam int DEF_HOLD_CYCLES    = 5;
  localparam int DEF_STAGGER_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES  = 10;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/rst_wdog_ctrl.sv
// Reset sequencer: holds all domain resets, releases them in a staggered order,
// waits for test_done plus a settle window, and guards the whole run with a cycle watchdog.
module rst_wdog_ctrl
  import rst_wdog_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic                   test_done,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   all_released,
  output logic                   busy,
  output logic                   pass,
  output logic                   timeout,
  output logic [CNT_W-1:0]       cycle_count,
  output state_t                 state_dbg
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST   = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOMAINS - 1);
  localparam bit               SKIP_STAG   = (NUM_DOMAINS == 1) || (STAGGER_CYCLES == 0);

  if (TIMEOUT_CYCLES <= HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES) begin : g_chk_timeout
    $error("rst_wdog_ctrl: TIMEOUT_CYCLES must exceed the full release sequence length");
  end
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_chk_cnt_w
    $error("rst_wdog_ctrl: CNT_W too small to hold TIMEOUT_CYCLES");
  end
  if ((NUM_DOMAINS < 1) || (HOLD_CYCLES < 1) || (SETTLE_CYCLES < 1)) begin : g_chk_ranges
    $error("rst_wdog_ctrl: NUM_DOMAINS, HOLD_CYCLES and SETTLE_CYCLES must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] phase;
  logic [IDX_W-1:0] idx;

  logic [CNT_W-1:0] phase_inc;
  logic [CNT_W-1:0] wd_inc;
  logic             active;
  logic             wd_expire;

  // Both counters saturate rather than wrap.
  always_comb begin
    phase_inc = (phase == CNT_MAX) ? phase : phase + CNT_W'(1);
    wd_inc    = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
    active    = (state == HOLD) || (state == STAGGER) || (state == RUN) || (state == SETTLE);
    wd_expire = active && (wd_inc >= WD_LIMIT);
  end

  assign state_dbg = state;

  // sw_reset_req and test_done are level-sampled on each rising edge; a single-cycle
  // high pulse is enough, and there is no acknowledge back to the requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HOLD;
      rst_out      <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      phase        <= '0;
      idx          <= '0;
    end else if (sw_reset_req) begin
      state        <= HOLD;
      rst_out      <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      phase        <= '0;
      idx          <= '0;
    end else begin
      if (active) cycle_count <= wd_inc;
      // Expiry pre-empts every state action, so timeout beats a simultaneous pass.
      if (wd_expire) begin
        state        <= TIMEOUT;
        timeout      <= 1'b1;
        busy         <= 1'b0;
        all_released <= 1'b0;
        rst_out      <= '1;
      end else begin
        case (state)
          HOLD: begin
            if (phase == HOLD_LAST) begin
              phase <= '0;
              if (SKIP_STAG) begin
                rst_out      <= '0;
                all_released <= 1'b1;
                state        <= RUN;
              end else begin
                rst_out[0] <= 1'b0;
                idx        <= IDX_W'(1);
                state      <= STAGGER;
              end
            end else begin
              phase <= phase_inc;
            end
          end
          STAGGER: begin
            if (phase == STAG_LAST) begin
              phase   <= '0;
              rst_out <= rst_out & ~(NUM_DOMAINS'(1) << idx);
              if (idx == LAST_IDX) begin
                all_released <= 1'b1;
                state        <= RUN;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              phase <= phase_inc;
            end
          end
          RUN: begin
            if (test_done) begin
              phase <= '0;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (phase == SETTLE_LAST) begin
              state <= PASS;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              phase <= phase_inc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_wdog_ctrl.sv
// Directed bench for rst_wdog_ctrl: default config, a short-timeout config and a zero-stagger config.
module tb_rst_wdog_ctrl;
  import rst_wdog_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic sw_a = 1'b0, sw_b = 1'b0, sw_c = 1'b0;
  logic td_a = 1'b0, td_b = 1'b0, td_c = 1'b0;

  logic [3:0]  ro_a, ro_b, ro_c;
  logic        ar_a, ar_b, ar_c;
  logic        bz_a, bz_b, bz_c;
  logic        ps_a, ps_b, ps_c;
  logic        to_a, to_b, to_c;
  logic [15:0] cc_a, cc_b, cc_c;
  state_t      st_a, st_b, st_c;

  rst_wdog_ctrl dut_a (
    .clk(clk), .reset(rst_a), .sw_reset_req(sw_a), .test_done(td_a),
    .rst_out(ro_a), .all_released(ar_a), .busy(bz_a), .pass(ps_a),
    .timeout(to_a), .cycle_count(cc_a), .state_dbg(st_a)
  );

  rst_wdog_ctrl #(.TIMEOUT_CYCLES(40), .SETTLE_CYCLES(10)) dut_b (
    .clk(clk), .reset(rst_b), .sw_reset_req(sw_b), .test_done(td_b),
    .rst_out(ro_b), .all_released(ar_b), .busy(bz_b), .pass(ps_b),
    .timeout(to_b), .cycle_count(cc_b), .state_dbg(st_b)
  );

  rst_wdog_ctrl #(.STAGGER_CYCLES(0)) dut_c (
    .clk(clk), .reset(rst_c), .sw_reset_req(sw_c), .test_done(td_c),
    .rst_out(ro_c), .all_released(ar_c), .busy(bz_c), .pass(ps_c),
    .timeout(to_c), .cycle_count(cc_c), .state_dbg(st_c)
  );

  // ---------------- scoreboard counters ----------------
  int compared   = 0;
  int mismatched = 0;
  int e          = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic step_to(input int target);
    while (e < target) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values while reset is held low.
    #12;
    chk("rst_rst_out",      ro_a, 4'hF);
    chk("rst_all_released", ar_a, 0);
    chk("rst_busy",         bz_a, 1);
    chk("rst_pass",         ps_a, 0);
    chk("rst_timeout",      to_a, 0);
    chk("rst_cycle_count",  cc_a, 0);
    chk("rst_state",        st_a, HOLD);

    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    e = 0;

    // Plain release and STAGGER_CYCLES=0 variant.
    step_to(4);
    chk("t1_e4_rst_out", ro_a, 4'hF);
    chk("t6_c_e4_rst_out", ro_c, 4'hF);
    step_to(5);
    chk("t1_e5_rst_out", ro_a, 4'hE);
    chk("t1_e5_all_rel", ar_a, 0);
    chk("t6_c_e5_rst_out", ro_c, 4'h0);
    chk("t6_c_e5_all_rel", ar_c, 1);
    step_to(6);
    chk("t1_e6_rst_out", ro_a, 4'hE);
    step_to(7);
    chk("t1_e7_rst_out", ro_a, 4'hC);
    step_to(9);
    chk("t1_e9_rst_out", ro_a, 4'h8);
    step_to(10);
    chk("t1_e10_all_rel", ar_a, 0);
    step_to(11);
    chk("t1_e11_rst_out", ro_a, 4'h0);
    chk("t1_e11_all_rel", ar_a, 1);
    chk("t1_e11_state",   st_a, RUN);
    chk("t1_e11_count",   cc_a, 11);

    // test_done pulse sampled at edge 20 on dut_a.
    step_to(19);
    td_a = 1'b1;
    step_to(20);
    td_a = 1'b0;
    step_to(29);
    chk("t2_e29_pass", ps_a, 0);
    chk("t2_e29_busy", bz_a, 1);
    td_b = 1'b1;
    step_to(30);
    td_b = 1'b0;
    chk("t2_e30_pass",    ps_a, 1);
    chk("t2_e30_busy",    bz_a, 0);
    chk("t2_e30_timeout", to_a, 0);
    chk("t2_e30_count",   cc_a, 30);
    chk("t2_e30_rst_out", ro_a, 4'h0);
    chk("t2_e30_all_rel", ar_a, 1);

    // Short-timeout config: pass and timeout both fall due at edge 40.
    step_to(39);
    chk("t5_e39_timeout", to_b, 0);
    chk("t5_e39_busy",    bz_b, 1);
    step_to(40);
    chk("t5_e40_timeout", to_b, 1);
    chk("t5_e40_pass",    ps_b, 0);
    chk("t5_e40_rst_out", ro_b, 4'hF);
    chk("t5_e40_count",   cc_b, 40);
    chk("t5_e40_state",   st_b, TIMEOUT);
    step_to(45);
    chk("t2_e45_count_frozen", cc_a, 30);
    chk("t2_e45_pass_sticky",  ps_a, 1);
    chk("t5_e45_count_frozen", cc_b, 40);

    // Asynchronous reset mid-RUN on dut_c, checked with no clock edge in between.
    chk("t6_c_pre_state", st_c, RUN);
    rst_c = 1'b0;
    #1;
    chk("t6_async_rst_out", ro_c, 4'hF);
    chk("t6_async_all_rel", ar_c, 0);
    chk("t6_async_count",   cc_c, 0);

    // Software restart mid-STAGGER on dut_a.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    e = 0;
    step_to(7);
    chk("t4_e7_rst_out", ro_a, 4'hC);
    sw_a = 1'b1;
    step_to(8);
    sw_a = 1'b0;
    chk("t4_e8_rst_out", ro_a, 4'hF);
    chk("t4_e8_count",   cc_a, 0);
    chk("t4_e8_busy",    bz_a, 1);
    chk("t4_e8_state",   st_a, HOLD);
    step_to(12);
    chk("t4_e12_rst_out", ro_a, 4'hF);
    step_to(13);
    chk("t4_e13_rst_out", ro_a, 4'hE);
    step_to(18);
    chk("t4_e18_rst_out", ro_a, 4'h8);
    step_to(19);
    chk("t4_e19_rst_out", ro_a, 4'h0);
    chk("t4_e19_all_rel", ar_a, 1);

    // Watchdog expiry on dut_a; a test_done pulse during HOLD must be ignored.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    e = 0;
    step_to(1);
    td_a = 1'b1;
    step_to(2);
    td_a = 1'b0;
    step_to(999);
    chk("t3_e999_timeout", to_a, 0);
    chk("t3_e999_pass",    ps_a, 0);
    chk("t3_e999_state",   st_a, RUN);
    chk("t3_e999_count",   cc_a, 999);
    step_to(1000);
    chk("t3_e1000_timeout", to_a, 1);
    chk("t3_e1000_rst_out", ro_a, 4'hF);
    chk("t3_e1000_all_rel", ar_a, 0);
    chk("t3_e1000_busy",    bz_a, 0);
    chk("t3_e1000_pass",    ps_a, 0);
    chk("t3_e1000_count",   cc_a, 1000);
    step_to(1010);
    chk("t3_e1010_count",   cc_a, 1000);
    chk("t3_e1010_timeout", to_a, 1);

    // Software restart out of TIMEOUT.
    sw_a = 1'b1;
    step_to(1011);
    sw_a = 1'b0;
    chk("t3_sw_timeout", to_a, 0);
    chk("t3_sw_busy",    bz_a, 1);
    chk("t3_sw_rst_out", ro_a, 4'hF);
    chk("t3_sw_count",   cc_a, 0);
    step_to(1016);
    chk("t3_sw_e5_rst_out", ro_a, 4'hE);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
